seg7_reader: RTL and testbench

- Receive-side counterpart of the counter/7-segment display driver.
- Monitors a two-digit 7-segment bus (tens, ones) and waits for the segment patterns to settle.
- Decodes the settled digits back to a binary value 0..99 and presents it on a valid/ready handshake.
- Sits in self-check and loopback paths wherever a display-driving block's output must be read back numerically.

---
 rtl/seg7_if.sv | 23 ++
 rtl/seg7_reader.sv | 120 ++++++++++++
 tb/tb_seg7_reader.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_if.sv
// Two-digit 7-segment read-back bus: segment inputs plus the decoded-word
// valid/ready handshake and the sticky overrun flag.
interface seg7_if #(
    parameter int unsigned W = 7
) ();
    logic [6:0]   ten_in;
    logic [6:0]   one_in;
    logic [W-1:0] value_out;
    logic         err_out;
    logic         out_valid;
    logic         out_ready;
    logic         overrun_out;

    modport slave (
        input  ten_in, one_in, out_ready,
        output value_out, err_out, out_valid, overrun_out
    );

    modport master (
        output ten_in, one_in, out_ready,
        input  value_out, err_out, out_valid, overrun_out
    );
endinterface

// File: rtl/seg7_reader.sv
// Waits for a two-digit 7-segment pattern pair to settle, decodes it to
// tens*10+ones and offers it on a valid/ready handshake.
module seg7_reader #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned W             = 7
) (
    input logic   clk,
    input logic   rst,
    seg7_if.slave bus
);
    typedef enum logic [0:0] {StIdle, StHold} state_t;

    localparam logic [7:0] CntMax  = 8'(STABLE_CYCLES);
    localparam logic [7:0] CntQual = 8'(STABLE_CYCLES - 1);

    state_t       state_q, state_d;
    logic [13:0]  samp_q, last_q;
    logic         last_valid_q;
    logic [7:0]   cnt_q;
    logic [W-1:0] value_q, value_d;
    logic         err_q, err_d;
    logic         ovr_q, ovr_d;

    logic [13:0] pair;
    logic        same;
    logic        qual;
    logic [4:0]  dig_ten, dig_one;
    logic [6:0]  sum;
    logic        illegal;

    // Returns {legal, digit}; anything outside the ten glyphs is illegal.
    function automatic logic [4:0] decode(input logic [6:0] seg);
        case (seg)
            7'b1111110: decode = {1'b1, 4'd0};
            7'b0110000: decode = {1'b1, 4'd1};
            7'b1101101: decode = {1'b1, 4'd2};
            7'b1111001: decode = {1'b1, 4'd3};
            7'b0110011: decode = {1'b1, 4'd4};
            7'b1011011: decode = {1'b1, 4'd5};
            7'b1011111: decode = {1'b1, 4'd6};
            7'b1110000: decode = {1'b1, 4'd7};
            7'b1111111: decode = {1'b1, 4'd8};
            7'b1111011: decode = {1'b1, 4'd9};
            default:    decode = 5'b0;
        endcase
    endfunction

    assign pair    = {bus.ten_in, bus.one_in};
    assign same    = (pair == samp_q);
    // cnt_q only passes CntQual once per run, so a held pair cannot re-trigger.
    assign qual    = same && (cnt_q == CntQual) && (!last_valid_q || samp_q != last_q);
    assign dig_ten = decode(samp_q[13:7]);
    assign dig_one = decode(samp_q[6:0]);
    assign illegal = !(dig_ten[4] && dig_one[4]);
    assign sum     = illegal ? 7'd0
                   : ({3'b000, dig_ten[3:0]} * 7'd10) + {3'b000, dig_one[3:0]};

    always_comb begin
        state_d = state_q;
        value_d = value_q;
        err_d   = err_q;
        ovr_d   = ovr_q;
        unique case (state_q)
            StIdle: begin
                if (qual) begin
                    value_d = W'(sum);
                    err_d   = illegal;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (bus.out_ready) begin
                    if (qual) begin
                        value_d = W'(sum);
                        err_d   = illegal;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (qual) begin
                    ovr_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            samp_q       <= '0;
            last_q       <= '0;
            last_valid_q <= 1'b0;
            cnt_q        <= '0;
            value_q      <= '0;
            err_q        <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            err_q   <= err_d;
            ovr_q   <= ovr_d;
            samp_q  <= pair;
            if (!same) begin
                cnt_q <= '0;
            end else if (cnt_q != CntMax) begin
                cnt_q <= cnt_q + 8'd1;
            end
            // Dropped words also update the last pair so they are never re-offered.
            if (qual) begin
                last_q       <= samp_q;
                last_valid_q <= 1'b1;
            end
        end
    end

    assign bus.value_out   = value_q;
    assign bus.err_out     = err_q;
    assign bus.out_valid   = (state_q == StHold);
    assign bus.overrun_out = ovr_q;
endmodule

// File: tb/tb_seg7_reader.sv
// Scoreboard bench for seg7_reader: two instances (STABLE_CYCLES 4 and 1) share
// segment stimulus and out_ready; a run-length reference model feeds per-instance queues.
module tb_seg7_reader;
    logic       clk = 1'b0;
    logic [1:0] rst = 2'b00;
    logic [6:0] ten = 7'd0;
    logic [6:0] one = 7'd0;
    logic       ready = 1'b0;

    always #5 clk = ~clk;

    seg7_if #(.W(8)) b0 ();
    seg7_if #(.W(7)) b1 ();

    assign b0.ten_in = ten;
    assign b0.one_in = one;
    assign b0.out_ready = ready;
    assign b1.ten_in = ten;
    assign b1.one_in = one;
    assign b1.out_ready = ready;

    seg7_reader #(.STABLE_CYCLES(4), .W(8)) dut0 (.clk(clk), .rst(rst[0]), .bus(b0));
    seg7_reader #(.STABLE_CYCLES(1), .W(7)) dut1 (.clk(clk), .rst(rst[1]), .bus(b1));

    logic [1:0] mv, mo, me;
    logic [7:0] mval [2];
    assign mv[0] = b0.out_valid;
    assign mv[1] = b1.out_valid;
    assign mo[0] = b0.overrun_out;
    assign mo[1] = b1.overrun_out;
    assign me[0] = b0.err_out;
    assign me[1] = b1.err_out;
    assign mval[0] = b0.value_out;
    assign mval[1] = {1'b0, b1.value_out};

    logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                 7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
    int unsigned stab [2] = '{4, 1};

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: capture history since reset, presented word, last accepted pair.
    logic [13:0] hist [2][$];
    logic [8:0]  exp_q [2][$];
    logic        m_hold [2] = '{1'b0, 1'b0};
    logic        m_ovr [2] = '{1'b0, 1'b0};
    logic        m_has [2] = '{1'b0, 1'b0};
    logic [13:0] m_acc [2];
    logic        m_just_rst [2] = '{1'b0, 1'b0};

    function automatic int digit_of(input logic [6:0] seg);
        for (int k = 0; k < 10; k++) if (seg_tab[k] == seg) return k;
        return -1;
    endfunction

    // {err, 8-bit value}
    function automatic logic [8:0] word_of(input logic [13:0] p);
        int t, o;
        t = digit_of(p[13:7]);
        o = digit_of(p[6:0]);
        if (t < 0 || o < 0) return {1'b1, 8'd0};
        return {1'b0, 8'(t * 10 + o)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a pair is accepted when exactly the last STABLE+1 captures (reset seeds a zero
    // capture) equal it and it differs from the previously accepted pair.
    initial forever begin
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!rst[i]) begin
                hist[i].delete();
                hist[i].push_back(14'd0);
                exp_q[i].delete();
                m_hold[i] = 1'b0;
                m_ovr[i] = 1'b0;
                m_has[i] = 1'b0;
                m_just_rst[i] = 1'b1;
            end else begin
                logic [13:0] p;
                int run;
                logic was_hold;
                p = {ten, one};
                m_just_rst[i] = 1'b0;
                hist[i].push_back(p);
                if (hist[i].size() > 300) void'(hist[i].pop_front());
                run = 0;
                for (int k = hist[i].size() - 1; k >= 0; k--) begin
                    if (hist[i][k] != p) break;
                    run++;
                end
                was_hold = m_hold[i];
                if (was_hold && ready) m_hold[i] = 1'b0;
                if (run == int'(stab[i]) + 1 && (!m_has[i] || m_acc[i] != p)) begin
                    m_has[i] = 1'b1;
                    m_acc[i] = p;
                    if (was_hold && !ready) begin
                        m_ovr[i] = 1'b1;
                    end else begin
                        exp_q[i].push_back(word_of(p));
                        m_hold[i] = 1'b1;
                    end
                end
            end
        end
    end

    // Monitor: compare handshake/flags every cycle, pop the scoreboard on each transfer.
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("valid[%0d]", i), 32'(mv[i]), 32'(m_hold[i]));
            chk($sformatf("overrun[%0d]", i), 32'(mo[i]), 32'(m_ovr[i]));
            if (m_just_rst[i]) begin
                chk($sformatf("rst_value[%0d]", i), 32'(mval[i]), 32'd0);
                chk($sformatf("rst_err[%0d]", i), 32'(me[i]), 32'd0);
            end
            if (mv[i] === 1'b1 && ready && rst[i]) begin
                if (exp_q[i].size() == 0) begin
                    chk($sformatf("unexpected_word[%0d]", i), 32'(mval[i]), 32'hffff);
                end else begin
                    logic [8:0] w;
                    w = exp_q[i].pop_front();
                    chk($sformatf("value[%0d]", i), 32'(mval[i]), 32'(w[7:0]));
                    chk($sformatf("err[%0d]", i), 32'(me[i]), 32'(w[8]));
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic show(input int t, input int o, input int n);
        ten = seg_tab[t];
        one = seg_tab[o];
        step(n);
    endtask

    initial begin
        int waited;
        step(2);
        rst = 2'b11;
        ready = 1'b1;
        show(4, 2, 10);
        show(4, 2, 50);
        show(4, 9, 2);
        show(4, 2, 10);
        show(9, 9, 10);
        ten = seg_tab[9];
        one = 7'b0000001;
        step(10);
        ten = 7'b0000000;
        one = 7'b0000000;
        step(8);

        // Blocked output: 12 held, 34 dropped, then 12 drained.
        ready = 1'b0;
        show(1, 2, 6);
        show(3, 4, 6);
        ready = 1'b1;
        step(4);

        // Consume 07 on the same edge 58 qualifies in the 4-cycle instance.
        rst = 2'b00;
        step(1);
        rst = 2'b11;
        ready = 1'b0;
        show(0, 7, 6);
        show(5, 8, 4);
        ready = 1'b1;
        step(5);

        // Reset the 1-cycle instance while it holds a word.
        ready = 1'b0;
        ten = seg_tab[3];
        one = seg_tab[5];
        waited = 0;
        while (b1.out_valid !== 1'b1 && waited < 20) begin
            step(1);
            waited++;
        end
        chk("wait_valid1", 32'(b1.out_valid), 32'd1);
        rst[1] = 1'b0;
        step(1);
        rst[1] = 1'b1;
        step(4);
        ready = 1'b1;
        step(4);

        // Randomized phase.
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                ten = 7'($urandom);
                one = 7'($urandom);
            end else if ($urandom_range(0, 5) != 0) begin
                ten = seg_tab[$urandom_range(0, 9)];
                one = seg_tab[$urandom_range(0, 9)];
            end
            ready = ($urandom_range(0, 3) != 0);
            step($urandom_range(1, 7));
        end
        ready = 1'b1;
        step(20);
        for (int i = 0; i < 2; i++)
            chk($sformatf("drained[%0d]", i), 32'(exp_q[i].size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
